// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch/decode boundary, CP0 and next-PC logic:
// text-segment limits, exception handler entry point and exception codes.
package if_id_stage_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_6FFC;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4
    } exccode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        exccode_e    exccode;
        logic        valid;
    } if_id_t;

    // A bubble keeps the PC and delay-slot flag so CP0 can still form EPC from it.
    function automatic if_id_t make_bubble(input logic [31:0] pc, input logic bd);
        if_id_t b;
        b.pc      = pc;
        b.instr   = '0;
        b.bd      = bd;
        b.exccode = EXC_NONE;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational address-error check: misalignment or address outside [LO, HI].
// Reused by the memory stage with its own range and access size.
module fetch_addr_check
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0]  LO    = TEXT_BASE,
    parameter logic [31:0]  HI    = TEXT_END,
    parameter int unsigned  ALIGN = 4
) (
    input  logic [31:0] addr,
    output logic        adel
);

    localparam logic [31:0] ALIGN_MASK = 32'(ALIGN - 1);

    logic misaligned;
    logic below;
    logic above;

    assign misaligned = (addr & ALIGN_MASK) != '0;
    assign below      = addr < LO;
    assign above      = addr > HI;
    assign adel       = misaligned | below | above;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures PC/instruction/delay-slot flag, tags AdEL,
// and supports stall, flush and redirect bubbles. Optional IF_ID_PERF_EN adds counters.
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        req,
    input  logic [31:0] f_pc,
    input  logic [31:0] f_instr,
    input  logic        f_bd,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_bd,
    output logic [4:0]  d_exccode,
    output logic        d_valid
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    if_id_t cur;
    if_id_t nxt;
    logic   adel;

    fetch_addr_check #(
        .LO    (TEXT_BASE),
        .HI    (TEXT_END),
        .ALIGN (4)
    ) u_fetch_addr_check (
        .addr (f_pc),
        .adel (adel)
    );

    // Priority below reset: req, flush, stall, load.
    always_comb begin
        nxt = cur;
        if (req) begin
            nxt = make_bubble(HANDLER_PC, 1'b0);
        end else if (flush) begin
            nxt = make_bubble(f_pc, f_bd);
        end else if (en) begin
            nxt.pc      = f_pc;
            nxt.bd      = f_bd;
            nxt.valid   = 1'b1;
            nxt.exccode = adel ? EXC_ADEL : EXC_NONE;
            nxt.instr   = adel ? '0 : f_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur <= make_bubble(TEXT_BASE, 1'b0);
        end else begin
            cur <= nxt;
        end
    end

    assign d_pc      = cur.pc;
    assign d_instr   = cur.instr;
    assign d_bd      = cur.bd;
    assign d_exccode = cur.exccode;
    assign d_valid   = cur.valid;

`ifdef IF_ID_PERF_EN
    logic stalling;
    logic bubbling;

    assign bubbling = req | flush;
    assign stalling = !en && !bubbling;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stalling && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bubbling && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Table-driven bench for if_id_stage; counter checks compiled in with IF_ID_PERF_EN.
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic        req;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_bd;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic        d_bd;
    logic [4:0]  d_exccode;
    logic        d_valid;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    if_id_stage dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .req       (req),
        .f_pc      (f_pc),
        .f_instr   (f_instr),
        .f_bd      (f_bd),
        .d_pc      (d_pc),
        .d_instr   (d_instr),
        .d_bd      (d_bd),
        .d_exccode (d_exccode),
        .d_valid   (d_valid)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        flush;
        logic        req;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_bd;
        logic [4:0]  e_exc;
        logic        e_valid;
        logic [31:0] e_stall;
        logic [31:0] e_bubble;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(
        input logic rst, input logic e, input logic fl, input logic rq,
        input logic [31:0] pc, input logic [31:0] instr, input logic bd,
        input logic [31:0] xpc, input logic [31:0] xinstr, input logic xbd,
        input logic [4:0] xexc, input logic xvalid,
        input logic [31:0] xstall, input logic [31:0] xbubble);
        vec_t r;
        r.rst = rst; r.en = e; r.flush = fl; r.req = rq;
        r.pc = pc; r.instr = instr; r.bd = bd;
        r.e_pc = xpc; r.e_instr = xinstr; r.e_bd = xbd;
        r.e_exc = xexc; r.e_valid = xvalid;
        r.e_stall = xstall; r.e_bubble = xbubble;
        return r;
    endfunction

    task automatic check32(input string name, input int row,
                           input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input vec_t x);
        check32("d_pc", row, d_pc, x.e_pc);
        check32("d_instr", row, d_instr, x.e_instr);
        check32("d_bd", row, {31'b0, d_bd}, {31'b0, x.e_bd});
        check32("d_exccode", row, {27'b0, d_exccode}, {27'b0, x.e_exc});
        check32("d_valid", row, {31'b0, d_valid}, {31'b0, x.e_valid});
`ifdef IF_ID_PERF_EN
        check32("stall_cnt", row, stall_cnt, x.e_stall);
        check32("bubble_cnt", row, bubble_cnt, x.e_bubble);
`endif
    endtask

    initial begin
        //          rst en fl rq  f_pc          f_instr        bd   d_pc          d_instr        bd exc   vld  stall bubble
        vecs[0]  = v(0, 1, 0, 0, 32'h0000_3000, 32'h1111_1111, 0, 32'h0000_3000, 32'h0,         0, 5'd0, 0, 0, 0);
        vecs[1]  = v(1, 1, 0, 0, 32'h0000_3000, 32'h2408_0001, 0, 32'h0000_3000, 32'h2408_0001, 0, 5'd0, 1, 0, 0);
        vecs[2]  = v(1, 0, 0, 0, 32'h0000_3004, 32'hAAAA_AAAA, 1, 32'h0000_3000, 32'h2408_0001, 0, 5'd0, 1, 1, 0);
        vecs[3]  = v(1, 0, 0, 0, 32'h0000_3008, 32'hBBBB_BBBB, 0, 32'h0000_3000, 32'h2408_0001, 0, 5'd0, 1, 2, 0);
        vecs[4]  = v(1, 0, 0, 0, 32'h0000_300C, 32'hCCCC_CCCC, 1, 32'h0000_3000, 32'h2408_0001, 0, 5'd0, 1, 3, 0);
        vecs[5]  = v(1, 0, 1, 0, 32'h0000_3010, 32'hDEAD_BEEF, 1, 32'h0000_3010, 32'h0,         1, 5'd0, 0, 3, 1);
        vecs[6]  = v(1, 0, 1, 1, 32'h0000_3014, 32'hDEAD_BEEF, 1, 32'h0000_4180, 32'h0,         0, 5'd0, 0, 3, 2);
        vecs[7]  = v(1, 1, 0, 0, 32'h0000_3002, 32'h0000_1234, 0, 32'h0000_3002, 32'h0,         0, 5'd4, 1, 3, 2);
        vecs[8]  = v(1, 1, 0, 0, 32'h0000_7000, 32'h0000_5678, 0, 32'h0000_7000, 32'h0,         0, 5'd4, 1, 3, 2);
        vecs[9]  = v(1, 1, 0, 0, 32'h0000_6FFC, 32'h8C00_0000, 1, 32'h0000_6FFC, 32'h8C00_0000, 1, 5'd0, 1, 3, 2);
        vecs[10] = v(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0000_0001, 0, 32'hFFFF_FFFC, 32'h0,         0, 5'd4, 1, 3, 2);
        vecs[11] = v(1, 1, 0, 0, 32'h0000_2FFC, 32'h0000_0002, 0, 32'h0000_2FFC, 32'h0,         0, 5'd4, 1, 3, 2);
        vecs[12] = v(1, 1, 0, 0, 32'h0000_4001, 32'h0000_0003, 1, 32'h0000_4001, 32'h0,         1, 5'd4, 1, 3, 2);
        vecs[13] = v(1, 1, 0, 1, 32'h0000_4004, 32'h0000_0004, 1, 32'h0000_4180, 32'h0,         0, 5'd0, 0, 3, 3);
        vecs[14] = v(1, 1, 0, 0, 32'h0000_4180, 32'h0000_0005, 0, 32'h0000_4180, 32'h0000_0005, 0, 5'd0, 1, 3, 3);
        vecs[15] = v(1, 0, 0, 0, 32'h0000_4184, 32'h0000_0006, 1, 32'h0000_4180, 32'h0000_0005, 0, 5'd0, 1, 4, 3);
        vecs[16] = v(0, 0, 0, 0, 32'h0000_4188, 32'h0000_0007, 1, 32'h0000_3000, 32'h0,         0, 5'd0, 0, 0, 0);
        vecs[17] = v(1, 0, 0, 0, 32'h0000_418C, 32'h0000_0008, 1, 32'h0000_3000, 32'h0,         0, 5'd0, 0, 1, 0);
        vecs[18] = v(0, 1, 1, 1, 32'h0000_5000, 32'h0000_0009, 1, 32'h0000_3000, 32'h0,         0, 5'd0, 0, 0, 0);
        vecs[19] = v(1, 1, 0, 0, 32'h0000_5000, 32'h0000_000A, 1, 32'h0000_5000, 32'h0000_000A, 1, 5'd0, 1, 0, 0);
        vecs[20] = v(1, 1, 1, 0, 32'h0000_3020, 32'h0000_000B, 0, 32'h0000_3020, 32'h0,         0, 5'd0, 0, 0, 1);

        reset = 1'b0; en = 1'b0; flush = 1'b0; req = 1'b0;
        f_pc = '0; f_instr = '0; f_bd = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            reset   = vecs[i].rst;
            en      = vecs[i].en;
            flush   = vecs[i].flush;
            req     = vecs[i].req;
            f_pc    = vecs[i].pc;
            f_instr = vecs[i].instr;
            f_bd    = vecs[i].bd;
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i]);
            @(negedge clk);
        end

        // Outputs must not follow inputs between edges; only the next edge moves them.
        reset = 1'b1; en = 1'b1; flush = 1'b0; req = 1'b0;
        f_pc = 32'h0000_3100; f_instr = 32'h0000_ABCD; f_bd = 1'b0;
        @(posedge clk);
        #1;
        check32("seq_load_pc", 100, d_pc, 32'h0000_3100);
        check32("seq_load_instr", 100, d_instr, 32'h0000_ABCD);
        f_pc = 32'h0000_0001; f_instr = 32'hFFFF_FFFF; f_bd = 1'b1; req = 1'b1;
        #2;
        check32("seq_nocomb_pc", 101, d_pc, 32'h0000_3100);
        check32("seq_nocomb_valid", 101, {31'b0, d_valid}, 32'd1);
        req = 1'b0;
        @(posedge clk);
        #1;
        check32("seq_adel_exc", 102, {27'b0, d_exccode}, 32'd4);
        check32("seq_adel_instr", 102, d_instr, 32'h0);
        check32("seq_adel_bd", 102, {31'b0, d_bd}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
